// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: op codes and helpers shared by the logic unit pipeline.
package logic_unit_pkg;
    localparam int LOP_W = 3;
    localparam logic [LOP_W-1:0] LOP_AND   = 3'b000;
    localparam logic [LOP_W-1:0] LOP_OR    = 3'b001;
    localparam logic [LOP_W-1:0] LOP_XOR   = 3'b010;
    localparam logic [LOP_W-1:0] LOP_NOR   = 3'b011;
    localparam logic [LOP_W-1:0] LOP_ANDN  = 3'b100;
    localparam logic [LOP_W-1:0] LOP_PASSA = 3'b101;
    function automatic logic is_illegal_op(input logic [LOP_W-1:0] op);
        return op[2] && op[1];
    endfunction
endpackage

// File: rtl/logic_unit_stage.sv
// logic_unit_stage: one pipeline register stage holding a valid bit and an opaque payload.
module logic_unit_stage #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic         up_valid,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            q     <= '0;
        end else begin
            valid <= flush ? 1'b0 : load ? up_valid : valid;
            if (load && up_valid && !flush) q <= d;
        end
    end
endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: pipelined WIDTH-bit logic unit with valid/ready, flush and tag pass-through.
// Optional output-transfer counter enabled by LOGIC_UNIT_PERF_CNT_EN.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [LOP_W-1:0] in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_illegal
`ifdef LOGIC_UNIT_PERF_CNT_EN
   ,input  logic             perf_clear,
    output logic [31:0]      perf_count
`endif
);
    localparam int PW = WIDTH + TAG_W + 2;
    logic [WIDTH-1:0]  res;
    logic              ill;
    logic [STAGES:0]   ld;
    logic [STAGES-1:0] uv;
    logic [STAGES-1:0] v;
    logic [PW-1:0]     d [STAGES+1];
    always_comb begin
        ill = is_illegal_op(in_op);
        res = in_op == LOP_AND   ? in_a & in_b    :
              in_op == LOP_OR    ? in_a | in_b    :
              in_op == LOP_XOR   ? in_a ^ in_b    :
              in_op == LOP_NOR   ? ~(in_a | in_b) :
              in_op == LOP_ANDN  ? in_a & ~in_b   :
              in_op == LOP_PASSA ? in_a           : '0;
    end
    assign d[0] = {res, in_tag, res == '0, ill};
    // A stage may load when empty or when the stage after it is loading; the chain ends at out_ready.
    always_comb begin
        ld[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) ld[k] = !v[k] || ld[k+1];
        in_ready = ld[0] && !flush;
        uv[0] = in_valid && in_ready;
        for (int k = 1; k < STAGES; k++) uv[k] = v[k-1];
    end
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic_unit_stage #(.W(PW)) u_stage (
            .clock   (clock),
            .reset   (reset),
            .flush   (flush),
            .up_valid(uv[i]),
            .load    (ld[i]),
            .d       (d[i]),
            .valid   (v[i]),
            .q       (d[i+1])
        );
    end
    assign out_valid = v[STAGES-1];
    assign {out_result, out_tag, out_zero, out_illegal} = d[STAGES];
`ifdef LOGIC_UNIT_PERF_CNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) perf_count <= '0;
        else if (perf_clear) perf_count <= '0;
        else if (out_valid && out_ready && !flush && perf_count != '1) perf_count <= perf_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed self-checking bench for logic_unit_pipe (STAGES=2, WIDTH=32, TAG_W=5).
module tb_logic_unit_pipe;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [2:0]  in_op = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        out_zero;
    logic        out_illegal;
`ifdef LOGIC_UNIT_PERF_CNT_EN
    logic        perf_clear = 1'b0;
    logic [31:0] perf_count;
`endif
    int passed = 0;
    int total = 0;
    logic [31:0] exp_r [6] = '{32'hF000_F000, 32'hFFF0_FFF0, 32'h0FF0_0FF0,
                               32'h000F_000F, 32'h00F0_00F0, 32'hF0F0_F0F0};

    logic_unit_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(5)) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_zero   (out_zero),
        .out_illegal(out_illegal)
`ifdef LOGIC_UNIT_PERF_CNT_EN
       ,.perf_clear (perf_clear),
        .perf_count (perf_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag);
        in_valid = v;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
    endtask

    initial begin
        #12;
        chk("reset_valid", out_valid, 0);
        chk("reset_result", out_result, 0);
        chk("reset_tag", out_tag, 0);
        chk("reset_flags", {out_zero, out_illegal}, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        // back-to-back ops with one result per cycle
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 3'(i), 32'hF0F0_F0F0, 32'hFF00_FF00, 5'(i));
            tick();
            if (i == 0) chk("first_latency", out_valid, 0);
            else begin
                chk("seq_valid", out_valid, 1);
                chk("seq_result", out_result, exp_r[i-1]);
                chk("seq_tag", out_tag, i - 1);
            end
        end
        drive(1'b0, 3'd0, 32'h0, 32'h0, 5'd0);
        tick();
        chk("seq_last_result", out_result, exp_r[5]);
        chk("seq_last_tag", out_tag, 5);
        tick();
        chk("seq_drained", out_valid, 0);
        // reserved op and zero flag
        drive(1'b1, 3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
        tick();
        drive(1'b1, 3'b000, 32'h1, 32'h2, 5'd8);
        tick();
        chk("ill_result", out_result, 0);
        chk("ill_flags", {out_zero, out_illegal}, 2'b11);
        chk("ill_tag", out_tag, 7);
        drive(1'b0, 3'd0, 32'h0, 32'h0, 5'd0);
        tick();
        chk("zero_result", out_result, 0);
        chk("zero_flags", {out_zero, out_illegal}, 2'b10);
        chk("zero_tag", out_tag, 8);
        tick();
        // backpressure
        out_ready = 1'b0;
        drive(1'b1, 3'b101, 32'd1, 32'h0, 5'd1);
        #1;
        chk("bp_ready0", in_ready, 1);
        tick();
        drive(1'b1, 3'b101, 32'd2, 32'h0, 5'd2);
        #1;
        chk("bp_ready1", in_ready, 1);
        tick();
        drive(1'b1, 3'b101, 32'd3, 32'h0, 5'd3);
        #1;
        chk("bp_full", in_ready, 0);
        chk("bp_hold_tag", out_tag, 1);
        tick();
        chk("bp_stable_valid", out_valid, 1);
        chk("bp_stable_tag", out_tag, 1);
        chk("bp_stable_result", out_result, 1);
        chk("bp_still_full", in_ready, 0);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        tick();
        chk("bp_tag2", out_tag, 2);
        chk("bp_result2", out_result, 2);
        drive(1'b0, 3'd0, 32'h0, 32'h0, 5'd0);
        tick();
        chk("bp_tag3", out_tag, 3);
        chk("bp_valid3", out_valid, 1);
        tick();
        chk("bp_drained", out_valid, 0);
        // flush with two in flight and a pending input
        drive(1'b1, 3'b101, 32'd10, 32'h0, 5'd10);
        tick();
        drive(1'b1, 3'b101, 32'd11, 32'h0, 5'd11);
        tick();
        chk("fl_pre_valid", out_valid, 1);
        chk("fl_pre_tag", out_tag, 10);
        drive(1'b1, 3'b101, 32'd12, 32'h0, 5'd12);
        flush = 1'b1;
        #1;
        chk("fl_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        drive(1'b0, 3'd0, 32'h0, 32'h0, 5'd0);
        chk("fl_valid0", out_valid, 0);
        tick();
        chk("fl_valid1", out_valid, 0);
        tick();
        chk("fl_valid2", out_valid, 0);
        // asynchronous reset between edges
        drive(1'b1, 3'b101, 32'd20, 32'h0, 5'd20);
        tick();
        drive(1'b1, 3'b101, 32'd21, 32'h0, 5'd21);
        tick();
        chk("rst_pre_valid", out_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_result", out_result, 0);
        chk("rst_tag", out_tag, 0);
        chk("rst_flags", {out_zero, out_illegal}, 0);
        drive(1'b0, 3'd0, 32'h0, 32'h0, 5'd0);
        tick();
        reset = 1'b0;
        drive(1'b1, 3'b000, 32'h0F0F, 32'h00FF, 5'd9);
        tick();
        chk("rst_new_lat", out_valid, 0);
        drive(1'b0, 3'd0, 32'h0, 32'h0, 5'd0);
        tick();
        chk("rst_new_valid", out_valid, 1);
        chk("rst_new_result", out_result, 32'h0000_000F);
        chk("rst_new_tag", out_tag, 9);
        tick();
`ifdef LOGIC_UNIT_PERF_CNT_EN
        perf_clear = 1'b1;
        tick();
        perf_clear = 1'b0;
        chk("perf_cleared", perf_count, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'b101, 32'(i), 32'h0, 5'(i));
            tick();
        end
        drive(1'b0, 3'd0, 32'h0, 32'h0, 5'd0);
        tick();
        tick();
        tick();
        chk("perf_five", perf_count, 5);
        out_ready = 1'b0;
        drive(1'b1, 3'b101, 32'd30, 32'h0, 5'd30);
        tick();
        drive(1'b0, 3'd0, 32'h0, 32'h0, 5'd0);
        tick();
        tick();
        chk("perf_stall", perf_count, 5);
        perf_clear = 1'b1;
        tick();
        perf_clear = 1'b0;
        chk("perf_zero", perf_count, 0);
        out_ready = 1'b1;
        drive(1'b1, 3'b101, 32'd31, 32'h0, 5'd31);
        tick();
        drive(1'b0, 3'd0, 32'h0, 32'h0, 5'd0);
        tick();
        tick();
        chk("perf_two", perf_count, 2);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
